// File: rtl/four_bit_seq_divider_pkg.sv
// Shared types for the 4-bit sequential restoring divider.
// The package name is four_bit_div_pkg; this file holds the FSM state type and the iteration count.
package four_bit_div_pkg;

  localparam int N_ITER = 4;
  localparam int CNT_W  = $clog2(N_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/four_bit_seq_divider_addsub.sv
// 4-bit adder-subtractor: sum = a + (b ^ {4{subtract}}) + subtract.
// cout is the true carry, so for subtraction cout=1 means a >= b.
module four_bit_adder_subtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       subtract,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] b_x;

  assign b_x = b ^ {4{subtract}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_x} + {4'b0000, subtract};

endmodule

// File: rtl/four_bit_seq_divider.sv
// 4-bit unsigned sequential restoring divider: one quotient bit per RUN cycle, four RUN cycles per operation.
// Optional macro DIVZERO_DETECT_EN adds the div_zero port and a one-cycle short path for divisor 0.
module four_bit_seq_divider
  import four_bit_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] Dividend,
  input  logic [3:0] Divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] Quotient,
  output logic [3:0] Remainder,
`ifdef DIVZERO_DETECT_EN
  output logic       div_zero,
`endif
  output state_t     dbg_state
);

  // Handshake: start is a request that is taken only on a rising edge where the
  // FSM is IDLE (busy=0, done=0); there is no back-pressure and no queuing.
  // done is a one-cycle valid strobe; Quotient/Remainder stay stable afterwards
  // until the next operation completes.

  state_t           state, state_nxt;
  logic [3:0]       q_r, d_r, r_r;
  logic [CNT_W-1:0] cnt;

  logic       msb_out, cout, qb, last_iter;
  logic [3:0] s_val, trial, r_nxt, q_nxt;

  // One restoring step: shift {R,Q} left by one, trial-subtract D from the upper part.
  assign msb_out = r_r[3];
  assign s_val   = {r_r[2:0], q_r[3]};

  four_bit_adder_subtractor u_addsub (
    .a        (s_val),
    .b        (d_r),
    .subtract (1'b1),
    .sum      (trial),
    .cout     (cout)
  );

  // A set msb_out means the 5-bit partial remainder is >= 16 > D, so it always subtracts.
  assign qb        = msb_out | cout;
  assign r_nxt     = qb ? trial : s_val;
  assign q_nxt     = {q_r[2:0], qb};
  assign last_iter = (cnt == CNT_W'(N_ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIVZERO_DETECT_EN
          state_nxt = (Divisor == 4'd0) ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= '0;
      d_r       <= '0;
      r_r       <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
`ifdef DIVZERO_DETECT_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_r <= Dividend;
            d_r <= Divisor;
            r_r <= '0;
            cnt <= '0;
`ifdef DIVZERO_DETECT_EN
            div_zero <= 1'b0;
            if (Divisor == 4'd0) begin
              Quotient  <= 4'hF;
              Remainder <= Dividend;
              div_zero  <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          q_r <= q_nxt;
          r_r <= r_nxt;
          cnt <= last_iter ? '0 : cnt + 1'b1;
          if (last_iter) begin
            Quotient  <= q_nxt;
            Remainder <= r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_four_bit_seq_divider.sv
// Self-checking bench for four_bit_seq_divider: vector table, random operands, and multi-cycle corner sequences.
// Build with or without +define+DIVZERO_DETECT_EN; expectations follow the macro.
module tb_four_bit_seq_divider;
  import four_bit_div_pkg::*;

`ifdef DIVZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic       clk, rst_n, start;
  logic [3:0] Dividend, Divisor;
  logic       busy, done;
  logic [3:0] Quotient, Remainder;
  logic       dz_obs;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];  // {div_zero, quotient, remainder}

  typedef struct {
    logic [3:0] dd;
    logic [3:0] dv;
    logic [3:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t tv[10];

  four_bit_seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .busy      (busy),
    .done      (done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
`ifdef DIVZERO_DETECT_EN
    .div_zero  (dz_obs),
`endif
    .dbg_state (dbg_state)
  );

`ifndef DIVZERO_DETECT_EN
  assign dz_obs = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [3:0] dd, input logic [3:0] dv);
    logic [3:0] q, r;
    logic       dz;
    if (dv == 4'd0) begin
      q  = 4'hF;
      r  = dd;
      dz = DZ_EN;
    end else begin
      q  = dd / dv;
      r  = dd % dv;
      dz = 1'b0;
    end
    return {dz, q, r};
  endfunction

  // scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) chk("busy_done_exclusive", 1, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 expected no pending result at %0t", $time);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("quotient", int'(Quotient), int'(e[7:4]));
          chk("remainder", int'(Remainder), int'(e[3:0]));
          if (DZ_EN) chk("div_zero", int'(dz_obs), int'(e[8]));
        end
      end
    end
  end

  // driver: one operation, checks latency, busy length and result hold
  task automatic do_op(input logic [3:0] dd, input logic [3:0] dv,
                       input logic [3:0] eq, input logic [3:0] er, input bit poke);
    int  c, busy_cnt, lat;
    bit  seen;
    lat = (DZ_EN && dv == 4'd0) ? 1 : N_ITER + 1;
    @(negedge clk);
    Dividend = dd;
    Divisor  = dv;
    start    = 1'b1;
    exp_q.push_back({(DZ_EN && dv == 4'd0), eq, er});
    @(negedge clk);
    start = 1'b0;
    c = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && c <= 12) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (poke && c == 2) begin
          start = 1'b1; Dividend = 4'd2; Divisor = 4'd1;
        end
        @(negedge clk);
        if (poke && c == 2) start = 1'b0;
        c++;
      end
    end
    chk("done_latency", c, lat);
    chk("busy_cycles", busy_cnt, lat - 1);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    @(negedge clk);
    chk("hold_quotient", int'(Quotient), int'(eq));
    chk("hold_remainder", int'(Remainder), int'(er));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; Dividend = 4'd0; Divisor = 4'd0;

    tv[0] = '{4'd13, 4'd4,  4'd3,  4'd1};
    tv[1] = '{4'd15, 4'd1,  4'd15, 4'd0};
    tv[2] = '{4'd15, 4'd15, 4'd1,  4'd0};
    tv[3] = '{4'd4,  4'd5,  4'd0,  4'd4};
    tv[4] = '{4'd0,  4'd7,  4'd0,  4'd0};
    tv[5] = '{4'd9,  4'd0,  4'd15, 4'd9};
    tv[6] = '{4'd6,  4'd4,  4'd1,  4'd2};
    tv[7] = '{4'd14, 4'd3,  4'd4,  4'd2};
    tv[8] = '{4'd1,  4'd15, 4'd0,  4'd1};
    tv[9] = '{4'd0,  4'd0,  4'd15, 4'd0};

    // reset state
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(Quotient), 0);
    chk("rst_remainder", int'(Remainder), 0);
    chk("rst_div_zero", int'(dz_obs), 0);
    chk("rst_state", int'(dbg_state), int'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      do_op(tv[i].dd, tv[i].dv, tv[i].q, tv[i].r, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [3:0] a, b;
      logic [8:0] m;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      m = model(a, b);
      do_op(a, b, m[7:4], m[3:0], 1'b0);
    end

    // start pulse during RUN must be ignored
    do_op(4'd13, 4'd4, 4'd3, 4'd1, 1'b1);
    repeat (8) @(negedge clk);

    // reset in the middle of RUN aborts without a done pulse
    Dividend = 4'd13; Divisor = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrun_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(Quotient), 0);
    chk("abort_remainder", int'(Remainder), 0);
    chk("abort_state", int'(dbg_state), int'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_op(4'd6, 4'd4, 4'd1, 4'd2, 1'b0);

    // back-to-back with start held high: one accept every N_ITER+2 cycles
    begin
      int  t[3];
      int  n_done;
      bit  prev;
      logic [8:0] m;
      m = model(4'd11, 4'd3);
      chk("model_11_3", int'(m[7:0]), int'({4'd3, 4'd2}));
      @(negedge clk);
      Dividend = 4'd11; Divisor = 4'd3; start = 1'b1;
      repeat (3) exp_q.push_back(m);
      n_done = 0; prev = 1'b0;
      for (int n = 1; n <= 30 && n_done < 3; n++) begin
        @(negedge clk);
        if (done) begin
          if (prev) chk("b2b_done_width", 2, 1);
          t[n_done] = n;
          n_done++;
          if (n_done == 3) start = 1'b0;
        end
        prev = done;
      end
      start = 1'b0;
      chk("b2b_count", n_done, 3);
      if (n_done == 3) begin
        chk("b2b_first", t[0], N_ITER + 1);
        chk("b2b_gap1", t[1] - t[0], N_ITER + 2);
        chk("b2b_gap2", t[2] - t[1], N_ITER + 2);
      end
      repeat (10) @(negedge clk);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
